perm_round_ctrl: RTL and testbench

//  Holds the 320-bit ASCON state register and sequences p^a / p^b permutations.

---
 rtl/perm_round_ctrl_pkg.sv | 21 ++
 rtl/perm_round_ctrl_if.sv | 30 +++
 rtl/perm_round_ctrl.sv | 100 ++++++++++
 tb/tb_perm_round_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/perm_round_ctrl_pkg.sv
// Shared types and constants for the ASCON permutation round controller.
// State words are indexed x0..x4 as word[0]..word[4] of type_state.
package perm_round_ctrl_pkg;

  typedef logic [4:0][63:0] type_state;

  localparam int ROUNDS_A_DEF = 12;
  localparam int ROUNDS_B_DEF = 6;

  localparam logic [3:0] LAST_ROUND = 4'd11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A permutation of N rounds uses the tail of the 12-round constant schedule.
  function automatic logic [3:0] first_round(input int rounds);
    return 4'(12 - rounds);
  endfunction

endpackage

// File: rtl/perm_round_ctrl_if.sv
// Control/state bundle between the round controller (slave) and its user plus
// round datapath (master).
interface perm_round_ctrl_if;
  import perm_round_ctrl_pkg::*;

  logic      load_i;
  logic      start_i;
  logic      mode_i;
  logic      end_key_i;
  logic      end_lsb_i;
  type_state state_i;
  type_state state_loop_i;
  type_state state_o;
  logic [3:0] round_o;
  logic      en_xor_end_key_o;
  logic      en_xor_lsb_o;
  logic      busy_o;
  logic      done_o;

  modport slave (
    input  load_i, start_i, mode_i, end_key_i, end_lsb_i, state_i, state_loop_i,
    output state_o, round_o, en_xor_end_key_o, en_xor_lsb_o, busy_o, done_o
  );

  modport master (
    output load_i, start_i, mode_i, end_key_i, end_lsb_i, state_i, state_loop_i,
    input  state_o, round_o, en_xor_end_key_o, en_xor_lsb_o, busy_o, done_o
  );

endinterface

// File: rtl/perm_round_ctrl.sv
// ASCON permutation round controller: holds the 320-bit state and sequences
// p^a / p^b through an external one-round datapath.
module perm_round_ctrl
  import perm_round_ctrl_pkg::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_DEF,
  parameter int ROUNDS_B = ROUNDS_B_DEF
) (
  input  logic              clock_i,
  input  logic              resetb_i,
  perm_round_ctrl_if.slave  bus
);

  localparam logic [3:0] FIRST_A = first_round(ROUNDS_A);
  localparam logic [3:0] FIRST_B = first_round(ROUNDS_B);

  logic [1:0] fsm_q, fsm_d;
  logic [3:0] round_q, round_d;
  type_state  state_q, state_d;
  logic       key_flag_q, key_flag_d;
  logic       lsb_flag_q, lsb_flag_d;
  logic       last_round;

  always_comb begin
    fsm_d      = fsm_q;
    round_d    = round_q;
    state_d    = state_q;
    key_flag_d = key_flag_q;
    lsb_flag_d = lsb_flag_q;
    last_round = (fsm_q == ST_RUN) && (round_q == LAST_ROUND);

    case (fsm_q)
      ST_IDLE: begin
        round_d = '0;
        if (bus.load_i) begin
          state_d = bus.state_i;
        end
        if (bus.start_i) begin
          fsm_d      = ST_RUN;
          round_d    = bus.mode_i ? FIRST_B : FIRST_A;
          key_flag_d = bus.end_key_i;
          lsb_flag_d = bus.end_lsb_i;
        end
      end
      ST_RUN: begin
        state_d = bus.state_loop_i;
        if (round_q == LAST_ROUND) begin
          fsm_d   = ST_DONE;
          round_d = '0;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      ST_DONE: begin
        fsm_d      = ST_IDLE;
        round_d    = '0;
        key_flag_d = 1'b0;
        lsb_flag_d = 1'b0;
      end
      default: begin
        fsm_d      = ST_IDLE;
        round_d    = '0;
        key_flag_d = 1'b0;
        lsb_flag_d = 1'b0;
      end
    endcase

    // Round values past the last round cannot occur; recover to IDLE if seen.
    if (round_q > LAST_ROUND) begin
      fsm_d      = ST_IDLE;
      round_d    = '0;
      key_flag_d = 1'b0;
      lsb_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q      <= ST_IDLE;
      round_q    <= '0;
      state_q    <= '0;
      key_flag_q <= 1'b0;
      lsb_flag_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      round_q    <= round_d;
      state_q    <= state_d;
      key_flag_q <= key_flag_d;
      lsb_flag_q <= lsb_flag_d;
    end
  end

  assign bus.state_o          = state_q;
  assign bus.round_o          = round_q;
  assign bus.busy_o           = (fsm_q == ST_RUN);
  assign bus.done_o           = (fsm_q == ST_DONE);
  assign bus.en_xor_end_key_o = last_round && key_flag_q;
  assign bus.en_xor_lsb_o     = last_round && lsb_flag_q;

endmodule

// File: tb/tb_perm_round_ctrl.sv
// Directed bench for perm_round_ctrl: models the ASCON round datapath and
// compares round sequencing, enables and final state against a reference.
module tb_perm_round_ctrl;
  import perm_round_ctrl_pkg::*;

  localparam logic [63:0] KEY_HI = 64'h0001020304050607;
  localparam logic [63:0] KEY_LO = 64'h08090a0b0c0d0e0f;

  logic clock_i;
  logic resetb_i;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  type_state cur_state;
  type_state iv_state;
  type_state exp_state;

  perm_round_ctrl_if bus ();

  perm_round_ctrl #(.ROUNDS_A(12), .ROUNDS_B(6)) dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .bus      (bus)
  );

  initial begin
    clock_i = 1'b0;
    forever #5 clock_i = ~clock_i;
  end

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state round_fn(input type_state s, input logic [3:0] r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    logic [7:0]  c;
    c  = {4'(4'hf - r), r};
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ {56'd0, c};
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    round_fn[0] = x0; round_fn[1] = x1; round_fn[2] = x2;
    round_fn[3] = x3; round_fn[4] = x4;
  endfunction

  function automatic type_state xor_end(input type_state s, input logic key, input logic lsb);
    xor_end = s;
    if (key) begin
      xor_end[3] = xor_end[3] ^ KEY_HI;
      xor_end[4] = xor_end[4] ^ KEY_LO;
    end
    if (lsb) xor_end[4] = xor_end[4] ^ 64'd1;
  endfunction

  function automatic type_state perm_model(input type_state s, input logic mode,
                                           input logic key, input logic lsb);
    perm_model = s;
    for (int r = (mode ? 6 : 0); r < 12; r++) begin
      perm_model = round_fn(perm_model, 4'(r));
      if (r == 11) perm_model = xor_end(perm_model, key, lsb);
    end
  endfunction

  // Round datapath driven by the controller's own outputs.
  always_comb begin
    bus.state_loop_i = xor_end(round_fn(bus.state_o, bus.round_o),
                               bus.en_xor_end_key_o, bus.en_xor_lsb_o);
  end

  task automatic check_output(input string tag, input logic [319:0] got,
                              input logic [319:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply_stimulus(input logic load, input logic start, input logic mode,
                                input logic key, input logic lsb, input type_state st);
    bus.load_i    = load;
    bus.start_i   = start;
    bus.mode_i    = mode;
    bus.end_key_i = key;
    bus.end_lsb_i = lsb;
    bus.state_i   = st;
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_busy"}, 320'(bus.busy_o), 320'd0);
    check_output({tag, "_done"}, 320'(bus.done_o), 320'd0);
    check_output({tag, "_round"}, 320'(bus.round_o), 320'd0);
    check_output({tag, "_en_key"}, 320'(bus.en_xor_end_key_o), 320'd0);
    check_output({tag, "_en_lsb"}, 320'(bus.en_xor_lsb_o), 320'd0);
  endtask

  // Entered one sample after the accepting edge; leaves while sampling DONE.
  task automatic run_body(input logic mode, input logic key, input logic lsb,
                          input bit junk, input type_state exp);
    int n;
    int first;
    n     = mode ? 6 : 12;
    first = 12 - n;
    for (int k = 0; k < n; k++) begin
      check_output("round", 320'(bus.round_o), 320'(first + k));
      check_output("busy", 320'(bus.busy_o), 320'd1);
      check_output("done_run", 320'(bus.done_o), 320'd0);
      check_output("en_key", 320'(bus.en_xor_end_key_o), 320'((k == n - 1) && key));
      check_output("en_lsb", 320'(bus.en_xor_lsb_o), 320'((k == n - 1) && lsb));
      if (junk) apply_stimulus(1'b1, 1'b1, ~mode, ~key, ~lsb, '1);
      step();
    end
    check_output("done", 320'(bus.done_o), 320'd1);
    check_output("busy_done", 320'(bus.busy_o), 320'd0);
    check_output("round_done", 320'(bus.round_o), 320'd0);
    check_output("result", bus.state_o, exp);
    if (junk) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic start_perm(input logic mode, input logic key, input logic lsb,
                            input logic load, input type_state ld_val, input bit junk);
    type_state exp;
    exp = perm_model(load ? ld_val : cur_state, mode, key, lsb);
    apply_stimulus(load, 1'b1, mode, key, lsb, ld_val);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    run_body(mode, key, lsb, junk, exp);
    cur_state = exp;
    step();
    check_idle("post_idle");
    check_output("post_state", bus.state_o, exp);
  endtask

  initial begin
    iv_state[0] = 64'h80400c0600000000;
    iv_state[1] = KEY_HI;
    iv_state[2] = KEY_LO;
    iv_state[3] = 64'h0011223344556677;
    iv_state[4] = 64'h8899aabbccddeeff;
    cur_state   = '0;
    resetb_i    = 1'b0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    step();
    step();
    check_idle("reset");
    check_output("reset_state", bus.state_o, 320'd0);
    resetb_i = 1'b1;

    $display("[TB] p^a with load, key+lsb at end");
    start_perm(1'b0, 1'b1, 1'b1, 1'b1, iv_state, 1'b0);
    $display("[TB] p^b on held state, no end XOR");
    start_perm(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    $display("[TB] p^b with load, key only");
    start_perm(1'b1, 1'b1, 1'b0, 1'b1, iv_state, 1'b0);
    $display("[TB] p^a, lsb only, junk inputs while running");
    start_perm(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
    step();
    check_idle("junk_idle");

    $display("[TB] load without start");
    exp_state = iv_state;
    exp_state[2] = 64'hdeadbeefcafef00d;
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, exp_state);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    check_idle("load_only");
    check_output("load_state", bus.state_o, exp_state);
    cur_state = exp_state;

    $display("[TB] back-to-back p^b with start held");
    apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    step();
    for (int run = 0; run < 2; run++) begin
      exp_state = perm_model(cur_state, 1'b1, 1'b0, 1'b0);
      run_body(1'b1, 1'b0, 1'b0, 1'b0, exp_state);
      cur_state = exp_state;
      if (run == 0) begin
        step();
        check_idle("b2b_gap");
        step();
      end else begin
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
        step();
        check_idle("b2b_end");
        step();
        check_idle("b2b_end2");
      end
    end

    $display("[TB] reset during p^a");
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, iv_state);
    step();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    for (int k = 0; k < 4; k++) step();
    check_output("mid_round", 320'(bus.round_o), 320'd4);
    resetb_i = 1'b0;
    step();
    check_idle("mid_reset");
    check_output("mid_reset_state", bus.state_o, 320'd0);
    resetb_i  = 1'b1;
    cur_state = '0;
    step();
    check_idle("after_reset");

    $display("[TB] p^b from cleared state");
    start_perm(1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
